// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - single-owner CPU/DMA memory bus arbiter with per-region wait states
// Optional ARB_DMA_BURST_LIMIT_EN caps consecutive DMA grants while the CPU is waiting.
module cpu_bus_arbiter #(
    parameter int WS_FAST = 0,
    parameter int WS_SLOW = 3
`ifdef ARB_DMA_BURST_LIMIT_EN
    ,
    parameter int DMA_BURST_MAX = 4
`endif
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [23:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_we,
    input  logic        cpu_vda,
    input  logic        cpu_vpa,
    output logic        cpu_rdy,
    output logic [7:0]  cpu_din,
    input  logic        dma_req,
    input  logic [23:0] dma_addr,
    input  logic [7:0]  dma_dout,
    input  logic        dma_we,
    output logic        dma_gnt,
    output logic        dma_ack,
    output logic [7:0]  dma_din,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [23:0] mem_addr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din
);

    typedef enum logic [1:0] {IDLE = 2'd0, CPU_ACC = 2'd1, DMA_ACC = 2'd2} state_t;

    localparam logic [3:0] WS_FAST_C = 4'(WS_FAST);
    localparam logic [3:0] WS_SLOW_C = 4'(WS_SLOW);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mem_we_q, mem_we_d;
    logic [23:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_dout_q, mem_dout_d;
    logic [7:0]  cpu_din_q, cpu_din_d;
    logic [7:0]  dma_din_q, dma_din_d;
    logic        cpu_valid;
    logic        grant_dma;
    logic        last_cycle;
    logic        cpu_done;

    // Banks $00-$01 sit on the slow bus.
    function automatic logic [3:0] region_ws(input logic [23:0] addr);
        return (addr[23:17] == 7'd0) ? WS_SLOW_C : WS_FAST_C;
    endfunction

    assign cpu_valid  = cpu_vda | cpu_vpa;
    assign last_cycle = (state_q != IDLE) && (cnt_q == 4'd0);
    assign cpu_done   = (state_q == CPU_ACC) && last_cycle;

`ifdef ARB_DMA_BURST_LIMIT_EN
    localparam int BW = $clog2(DMA_BURST_MAX + 2);
    localparam logic [BW-1:0] BURST_MAX_C = BW'(DMA_BURST_MAX);

    logic [BW-1:0] burst_q, burst_d;

    assign grant_dma = dma_req && !(cpu_valid && (burst_q >= BURST_MAX_C));

    // Only DMA grants taken while the CPU waits count toward the cap.
    always_comb begin
        burst_d = burst_q;
        if (state_q == IDLE) begin
            if (grant_dma && cpu_valid) begin
                burst_d = burst_q + 1'b1;
            end else begin
                burst_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign grant_dma = dma_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        cpu_din_d  = cpu_din_q;
        dma_din_d  = dma_din_q;
        case (state_q)
            IDLE: begin
                if (grant_dma) begin
                    state_d    = DMA_ACC;
                    mem_addr_d = dma_addr;
                    mem_dout_d = dma_dout;
                    mem_we_d   = dma_we;
                    cnt_d      = region_ws(dma_addr);
                end else if (cpu_valid) begin
                    state_d    = CPU_ACC;
                    mem_addr_d = cpu_addr;
                    mem_dout_d = cpu_dout;
                    mem_we_d   = cpu_we;
                    cnt_d      = region_ws(cpu_addr);
                end
            end
            CPU_ACC, DMA_ACC: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (!mem_we_q) begin
                        if (state_q == CPU_ACC) begin
                            cpu_din_d = mem_din;
                        end else begin
                            dma_din_d = mem_din;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 24'd0;
            mem_dout_q <= 8'd0;
            cpu_din_q  <= 8'd0;
            dma_din_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_dout_q <= mem_dout_d;
            cpu_din_q  <= cpu_din_d;
            dma_din_q  <= dma_din_d;
        end
    end

    assign mem_cs   = (state_q != IDLE);
    assign mem_we   = mem_cs & mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_dout = mem_dout_q;
    assign dma_gnt  = (state_q == DMA_ACC);
    assign dma_ack  = dma_gnt & last_cycle;
    assign cpu_rdy  = cpu_done | (!cpu_valid && (state_q != CPU_ACC));
    // Read data is forwarded in the completion cycle, then held from the capture register.
    assign cpu_din  = (cpu_done && !mem_we_q) ? mem_din : cpu_din_q;
    assign dma_din  = (dma_ack && !mem_we_q) ? mem_din : dma_din_q;

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - scoreboard bench for cpu_bus_arbiter (default parameters)
module tb_cpu_bus_arbiter;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [23:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic        cpu_we;
    logic        cpu_vda;
    logic        cpu_vpa;
    logic        cpu_rdy;
    logic [7:0]  cpu_din;
    logic        dma_req;
    logic [23:0] dma_addr;
    logic [7:0]  dma_dout;
    logic        dma_we;
    logic        dma_gnt;
    logic        dma_ack;
    logic [7:0]  dma_din;
    logic        mem_cs;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;

    cpu_bus_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .cpu_vda(cpu_vda), .cpu_vpa(cpu_vpa), .cpu_rdy(cpu_rdy), .cpu_din(cpu_din),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_we(dma_we),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_din(dma_din),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_dout(mem_dout),
        .mem_din(mem_din)
    );

    always #5 CLK = ~CLK;

    // Memory model: read data is a fixed function of the low address byte.
    assign mem_din = mem_addr[7:0] ^ 8'h7A;

    typedef struct {
        bit          is_dma;
        logic [23:0] addr;
        logic        we;
        logic [7:0]  wdata;
        int          cs_len;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cs_len = 0;
    int cpu_done_cyc = 0;
    int dma_done_cyc = 0;
    int dma_ack_cnt = 0;
    int cpu_left = 0;
    int dma_left = 0;
    int cpu_idx = 0;
    int dma_idx = 0;
    logic [23:0] cpu_base;
    logic [23:0] dma_base;

    function automatic exp_t mk(input bit d, input logic [23:0] a, input logic we, input logic [7:0] wd);
        exp_t e;
        e.is_dma = d;
        e.addr   = a;
        e.we     = we;
        e.wdata  = wd;
        e.cs_len = (a[23:17] == 7'd0) ? 4 : 1;
        return e;
    endfunction

    always @(negedge CLK) begin : monitor
        exp_t e;
        logic done_dma, done_cpu;
        logic [7:0] rd;
        cyc++;
        done_dma = dma_ack;
        done_cpu = cpu_rdy && mem_cs && !dma_gnt;
        if (mem_cs) cs_len++;
        if (done_dma || done_cpu) begin
            if (done_dma) begin
                dma_done_cyc = cyc;
                dma_ack_cnt++;
            end else begin
                cpu_done_cyc = cyc;
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: completion dma=%0b addr=%h with nothing expected", done_dma, mem_addr);
            end else begin
                e = sb.pop_front();
                checks++;
                if (done_dma !== e.is_dma) begin
                    errors++;
                    $display("FAIL sb_owner: got dma=%0b required dma=%0b (addr %h)", done_dma, e.is_dma, e.addr);
                end
                checks++;
                if (mem_addr !== e.addr) begin
                    errors++;
                    $display("FAIL sb_addr: got %h required %h", mem_addr, e.addr);
                end
                checks++;
                if (mem_we !== e.we) begin
                    errors++;
                    $display("FAIL sb_we: got %b required %b", mem_we, e.we);
                end
                checks++;
                if (e.we) begin
                    if (mem_dout !== e.wdata) begin
                        errors++;
                        $display("FAIL sb_wdata: got %h required %h", mem_dout, e.wdata);
                    end
                end else begin
                    rd = done_dma ? dma_din : cpu_din;
                    if (rd !== (e.addr[7:0] ^ 8'h7A)) begin
                        errors++;
                        $display("FAIL sb_rdata: got %h required %h", rd, e.addr[7:0] ^ 8'h7A);
                    end
                end
                checks++;
                if (cs_len != e.cs_len) begin
                    errors++;
                    $display("FAIL sb_cs_len: got %0d required %0d (addr %h)", cs_len, e.cs_len, e.addr);
                end
            end
            cs_len = 0;
        end else if (!mem_cs) begin
            cs_len = 0;
        end
    end

    task automatic start_cpu(input logic [23:0] a, input logic we, input logic [7:0] d, input int n);
        cpu_base = a; cpu_idx = 0; cpu_addr = a; cpu_we = we; cpu_dout = d;
        cpu_left = n; cpu_vda = 1'b1;
    endtask

    task automatic start_dma(input logic [23:0] a, input logic we, input logic [7:0] d, input int n);
        dma_base = a; dma_idx = 0; dma_addr = a; dma_we = we; dma_dout = d;
        dma_left = n; dma_req = 1'b1;
    endtask

    // Bus masters: hold requests until the planned number of completions is seen.
    task automatic serve(input int max_cycles);
        bit ack, rdy;
        int n = 0;
        while ((dma_left > 0 || cpu_left > 0) && n < max_cycles) begin
            @(negedge CLK);
            ack = dma_ack;
            rdy = (cpu_vda | cpu_vpa) && cpu_rdy;
            @(posedge CLK); #1;
            if (ack && dma_left > 0) begin
                dma_left--; dma_idx++;
                if (dma_left == 0) dma_req = 1'b0;
                else dma_addr = dma_base + 24'(dma_idx);
            end
            if (rdy && cpu_left > 0) begin
                cpu_left--; cpu_idx++;
                if (cpu_left == 0) cpu_vda = 1'b0;
                else cpu_addr = cpu_base + 24'(cpu_idx);
            end
            n++;
        end
        checks++;
        if (dma_left != 0 || cpu_left != 0) begin
            errors++;
            $display("FAIL serve_timeout: dma_left=%0d cpu_left=%0d required 0", dma_left, cpu_left);
            dma_req = 1'b0; cpu_vda = 1'b0; dma_left = 0; cpu_left = 0;
        end
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        cpu_addr = 24'h0; cpu_dout = 8'h0; cpu_we = 1'b0; cpu_vda = 1'b0; cpu_vpa = 1'b0;
        dma_req = 1'b0; dma_addr = 24'h0; dma_dout = 8'h0; dma_we = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checks++;
        if ({mem_cs, mem_we, dma_gnt, dma_ack} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: cs/we/gnt/ack=%b required 0000", {mem_cs, mem_we, dma_gnt, dma_ack});
        end
        checks++;
        if ({mem_addr, mem_dout} !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h dout=%h required 0", mem_addr, mem_dout);
        end
        checks++;
        if ({cpu_din, dma_din} !== 16'h0) begin
            errors++;
            $display("FAIL reset_din: cpu_din=%h dma_din=%h required 0", cpu_din, dma_din);
        end
        checks++;
        if (cpu_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_rdy: got %b required 1", cpu_rdy);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        checks++;
        if ({cpu_rdy, mem_cs} !== 2'b10) begin
            errors++;
            $display("FAIL idle_after_reset: rdy/cs=%b required 10", {cpu_rdy, mem_cs});
        end
    endtask

    task automatic test_cpu_read_slow;
        int start;
        @(posedge CLK); #1;
        start = cyc;
        sb.push_back(mk(1'b0, 24'h00D020, 1'b0, 8'h00));
        start_cpu(24'h00D020, 1'b0, 8'h00, 1);
        serve(20);
        checks++;
        if (cpu_done_cyc - start != 5) begin
            errors++;
            $display("FAIL cpu_read_latency: got %0d required 5", cpu_done_cyc - start);
        end
        @(negedge CLK);
        checks++;
        if (cpu_din !== 8'h5A) begin
            errors++;
            $display("FAIL cpu_din_hold: got %h required 5a", cpu_din);
        end
    endtask

    task automatic test_cpu_write_fast;
        int start;
        @(posedge CLK); #1;
        start = cyc;
        sb.push_back(mk(1'b0, 24'h020000, 1'b1, 8'hA5));
        start_cpu(24'h020000, 1'b1, 8'hA5, 1);
        serve(20);
        checks++;
        if (cpu_done_cyc - start != 2) begin
            errors++;
            $display("FAIL cpu_write_latency: got %0d required 2", cpu_done_cyc - start);
        end
        @(negedge CLK);
        checks++;
        if ({mem_cs, mem_we, mem_addr, mem_dout, cpu_din} !== {2'b00, 24'h020000, 8'hA5, 8'h5A}) begin
            errors++;
            $display("FAIL write_hold: cs=%b we=%b addr=%h dout=%h cpu_din=%h required 0 0 020000 a5 5a",
                     mem_cs, mem_we, mem_addr, mem_dout, cpu_din);
        end
    endtask

    task automatic test_dma_then_cpu;
        int start;
        @(posedge CLK); #1;
        start = cyc;
        sb.push_back(mk(1'b1, 24'h300033, 1'b0, 8'h00));
        sb.push_back(mk(1'b0, 24'h200044, 1'b0, 8'h00));
        start_dma(24'h300033, 1'b0, 8'h00, 1);
        start_cpu(24'h200044, 1'b0, 8'h00, 1);
        serve(30);
        checks++;
        if (dma_done_cyc - start != 2) begin
            errors++;
            $display("FAIL dma_first_latency: got %0d required 2", dma_done_cyc - start);
        end
        checks++;
        if (cpu_done_cyc - dma_done_cyc != 2) begin
            errors++;
            $display("FAIL idle_gap: cpu done %0d cycles after dma, required 2", cpu_done_cyc - dma_done_cyc);
        end
    endtask

    task automatic test_burst;
        string pat;
        int di = 0;
        int ci = 0;
`ifdef ARB_DMA_BURST_LIMIT_EN
        pat = "DDDDCDDDDC";
`else
        pat = "DDDDDDDDCC";
`endif
        @(posedge CLK); #1;
        for (int i = 0; i < pat.len(); i++) begin
            if (pat.getc(i) == "D") begin
                sb.push_back(mk(1'b1, 24'h1000A0 + 24'(di), 1'b0, 8'h00));
                di++;
            end else begin
                sb.push_back(mk(1'b0, 24'h2000C0 + 24'(ci), 1'b0, 8'h00));
                ci++;
            end
        end
        start_dma(24'h1000A0, 1'b0, 8'h00, 8);
        start_cpu(24'h2000C0, 1'b0, 8'h00, 2);
        serve(100);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL burst_drain: %0d expected accesses left, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid_dma;
        int start;
        int acks;
        @(posedge CLK); #1;
        acks = dma_ack_cnt;
        sb.push_back(mk(1'b0, 24'h00D021, 1'b0, 8'h00));
        start_dma(24'h010000, 1'b0, 8'h00, 1);
        start_cpu(24'h00D021, 1'b0, 8'h00, 1);
        @(posedge CLK);
        @(posedge CLK); #2;
        checks++;
        if ({mem_cs, dma_gnt} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_gnt: cs/gnt=%b required 11", {mem_cs, dma_gnt});
        end
        RST_N = 1'b0;
        #1;
        checks++;
        if ({mem_cs, dma_gnt, dma_ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_abandon: cs/gnt/ack=%b required 000", {mem_cs, dma_gnt, dma_ack});
        end
        dma_req = 1'b0;
        dma_left = 0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        start = cyc;
        serve(20);
        checks++;
        if (cpu_done_cyc - start != 5) begin
            errors++;
            $display("FAIL post_reset_latency: got %0d required 5", cpu_done_cyc - start);
        end
        checks++;
        if ({dma_din, dma_ack_cnt - acks} !== {8'h00, 32'd0}) begin
            errors++;
            $display("FAIL post_reset_dma: dma_din=%h acks=%0d required 00 0", dma_din, dma_ack_cnt - acks);
        end
    endtask

    task automatic test_dma_drop;
        int acks;
        @(posedge CLK); #1;
        acks = dma_ack_cnt;
        sb.push_back(mk(1'b1, 24'h000100, 1'b0, 8'h00));
        start_dma(24'h000100, 1'b0, 8'h00, 1);
        @(posedge CLK);
        @(posedge CLK); #1;
        dma_req  = 1'b0;
        dma_left = 0;
        dma_addr = 24'hFFFFFF;
        repeat (8) @(negedge CLK);
        checks++;
        if (dma_ack_cnt - acks != 1) begin
            errors++;
            $display("FAIL drop_ack_count: got %0d required 1", dma_ack_cnt - acks);
        end
        checks++;
        if (dma_din !== 8'h7A) begin
            errors++;
            $display("FAIL drop_dma_din: got %h required 7a", dma_din);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read_slow();
        test_cpu_write_fast();
        test_dma_then_cpu();
        test_burst();
        test_reset_mid_dma();
        test_dma_drop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d expected accesses never completed", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
